coin_acceptor: RTL and testbench
================================

Name: coin_acceptor

Overview:
- Front-end stage of the vending machine; sits directly upstream of the 30-cent sale FSM.
- Takes four raw, bouncy, asynchronous switch inputs: 5c, 10c and 25c coin sensors plus the cancel button.
- Synchronises and debounces each input, then detects presses.
- Emits exactly one encoded coin/cancel event per press on `in[1:0]` with a one-cycle `confirm` strobe, which is the interface the sale FSM samples on posedge `clk`.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles an input must hold a new level before the debounced level changes (legal range 2..15).
- LOCKOUT_CYCLES, 3, minimum cycles after an emitted event before a new event may be emitted (legal range 1..15).

Ports:
- clk  input  1  system clock; all state on posedge
- rst  input  1  asynchronous active-high reset
- sw_5  input  1  raw 5c coin sensor, active high, asynchronous
- sw_10  input  1  raw 10c coin sensor, active high, asynchronous
- sw_25  input  1  raw 25c coin sensor, active high, asynchronous
- sw_cancel  input  1  raw cancel button, active high, asynchronous
- in  output  2  event code to sale FSM: 01=5c, 10=10c, 11=25c, 00=cancel; registered
- confirm  output  1  one-cycle strobe, `in` valid when high; registered
- err  output  1  one-cycle pulse on rejected or dropped press; registered

Behaviour:
- Reset (async, rst=1):
  - `in`=00, `confirm`=0, `err`=0.
  - All synchronisers, debounce counters and debounced levels are 0.
  - FSM is in IDLE.
- Synchronisation: each raw input passes through a two-flop synchroniser; nothing downstream uses raw inputs.
- Debounce, per input:
  - 4-bit counter, cleared whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments.
  - The debounced level toggles when the counter would reach DEBOUNCE_CYCLES; the counter clears at the same time.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes the debounced level.
- Press detect: a rising edge of a debounced level is a press; falling edges are ignored.
- Latency: a raw input first sampled high at edge E0 and held produces `confirm`=1 in the cycle following edge E0+DEBOUNCE_CYCLES+2. With the default this is 6 edges.
- FSM:
  - IDLE:
    - Exactly one press this cycle: register its code on `in`, set `confirm`=1, go to EMIT.
    - Two or more presses in the same cycle: no `confirm`, `err`=1 for one cycle, stay in IDLE.
  - EMIT: lasts one cycle. Drop `confirm` to 0, hold `in` at its code, load the lockout timer with LOCKOUT_CYCLES-1, go to LOCK.
  - LOCK:
    - The timer decrements each cycle.
    - Any press seen in EMIT or LOCK is dropped with a one-cycle `err` pulse.
    - When the timer is 0 and all four debounced levels are 0, drive `in`=00 and go to IDLE.
    - A switch still held keeps the FSM in LOCK indefinitely, so a held coin never repeats.
- Code value: `in` returns to 00 only on the LOCK->IDLE exit. The sale FSM must qualify `in` with `confirm`; 00 with `confirm`=0 is idle, not cancel.
- Cancel: encoded identically to a coin (00), subject to the same debounce, lockout and collision rules.
- Reset mid-operation:
  - A pending EMIT/LOCK is abandoned.
  - A switch held across reset release is seen as a fresh press once debounced and produces one event.
- Back-to-back spacing: events are separated by at least 2+LOCKOUT_CYCLES cycles.

Optional Feature:
- COIN_TOTAL_EN defined:
  - Adds output port `total_cents`, 12 bits, reset 0.
  - On every `confirm` the value of the emitted coin (5/10/25) is added; cancel adds 0.
  - Saturates at 4095, no wrap.
  - The update is visible in the cycle after `confirm`.
- Not defined: port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset, sw_10 held high 20 cycles: `confirm` high exactly one cycle, 6 edges after the first high sample, `in`=10, `err`=0; `in` returns to 00 only after sw_10 released and debounced low.
- sw_25 bounces 1/0/1 at 1-cycle intervals, then stable high: only one `confirm`, `in`=11. A 3-cycle sw_5 glitch alone gives no `confirm`.
- sw_5 and sw_cancel rising on the same edge, both held: no `confirm`, one `err` pulse, FSM stays in IDLE.
- sw_5 press, then sw_10 pressed 2 cycles after `confirm` while in LOCK: `err` pulse, no second `confirm`. After both are released, sw_10 pressed again gives `confirm` with `in`=10.
- Sequence 25c, 5c, cancel, each pressed and released cleanly: three `confirm` strobes with `in` = 11, 01, 00. With COIN_TOTAL_EN, `total_cents` goes 25 -> 30 -> 30.
- rst asserted 2 cycles after `confirm` while sw_10 still held: outputs 0 immediately. After release of rst, one new `confirm` with `in`=10 after the debounce latency.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: front end of the vending machine. Synchronises and debounces
// the 5c/10c/25c coin sensors and the cancel button, detects presses and hands
// exactly one encoded event per press to the sale FSM as in[1:0] + confirm.
// Optional build macro COIN_TOTAL_EN adds a saturating 12-bit total_cents
// output accumulating the value of every confirmed coin.
//
// state | meaning
// IDLE  | waiting for a single debounced press
// EMIT  | confirm strobe cycle, in holds the event code
// LOCK  | lockout; presses are dropped with err until timer expires and all
//       | switches are released
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_5,
    input  logic       sw_10,
    input  logic       sw_25,
    input  logic       sw_cancel,
    output logic [1:0] in,
    output logic       confirm,
    output logic       err
`ifdef COIN_TOTAL_EN
    ,
    output logic [11:0] total_cents
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EMIT = 2'd1;
    localparam logic [1:0] LOCK = 2'd2;

    localparam logic [3:0] DB_LAST   = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] LOCK_LOAD = 4'(LOCKOUT_CYCLES - 1);

    // Bit index equals the event code: 0=cancel, 1=5c, 2=10c, 3=25c.
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] cnt [4];
    logic [3:0] db;
    logic [3:0] db_d;
    logic [3:0] press;
    logic       multi;
    logic       single;
    logic [1:0] code;
    logic [1:0] state;
    logic [3:0] timer;

    assign raw = {sw_25, sw_10, sw_5, sw_cancel};

    // Two-flop synchroniser on every raw switch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-input debounce: level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing synchronised samples; db_d keeps last cycle's level for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
            db   <= '0;
            db_d <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    db[i]  <= ~db[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 4'd1;
                end
            end
        end
    end

    assign press  = db & ~db_d;
    assign multi  = |(press & (press - 4'd1));
    assign single = (|press) && !multi;

    // Encode the (single) pressed input as its event code.
    always_comb begin
        code = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (press[i]) code = 2'(i);
        end
    end

    // Event FSM: emit one press, then lock out until timer expiry and full release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            in      <= 2'd0;
            confirm <= 1'b0;
            err     <= 1'b0;
            timer   <= '0;
        end else begin
            confirm <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (single) begin
                        in      <= code;
                        confirm <= 1'b1;
                        state   <= EMIT;
                    end else if (multi) begin
                        err <= 1'b1;
                    end
                end
                EMIT: begin
                    timer <= LOCK_LOAD;
                    state <= LOCK;
                    if (|press) err <= 1'b1;
                end
                LOCK: begin
                    if (|press) err <= 1'b1;
                    if (timer != 4'd0) begin
                        timer <= timer - 4'd1;
                    end else if (db == 4'd0) begin
                        in    <= 2'd0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COIN_TOTAL_EN
    logic [4:0]  coin_val;
    logic [12:0] sum;

    always_comb begin
        case (in)
            2'd1:    coin_val = 5'd5;
            2'd2:    coin_val = 5'd10;
            2'd3:    coin_val = 5'd25;
            default: coin_val = 5'd0;
        endcase
        sum = {1'b0, total_cents} + {8'd0, coin_val};
    end

    // Saturating accumulation of confirmed coin values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_cents <= '0;
        end else if (confirm) begin
            total_cents <= sum[12] ? 12'hFFF : sum[11:0];
        end
    end
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int LCK = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw_5 = 1'b0, sw_10 = 1'b0, sw_25 = 1'b0, sw_cancel = 1'b0;
    logic [1:0] in;
    logic       confirm, err;
`ifdef COIN_TOTAL_EN
    logic [11:0] total_cents;
`endif

    coin_acceptor #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LCK)) dut (
        .clk(clk), .rst(rst),
        .sw_5(sw_5), .sw_10(sw_10), .sw_25(sw_25), .sw_cancel(sw_cancel),
        .in(in), .confirm(confirm), .err(err)
`ifdef COIN_TOTAL_EN
        , .total_cents(total_cents)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: switch bits {25,10,5,cancel}; event timing tracked by edge stamps.
    bit [3:0] m_h1, m_h2, m_db, m_dbd;
    int       m_run [4];
    bit       m_ready;
    int       m_emit;
    int       m_edge;
    bit [1:0] m_in;
    bit       m_conf, m_err;
    int       m_total;

    int       n_conf, n_err, nsteps, first_conf;
    bit [1:0] last_code;

    typedef struct {
        bit [3:0] sw;
        int       hold;
        int       exp_conf;
        int       exp_err;
        bit [1:0] exp_code;
    } vec_t;
    vec_t vecs [10];

    function automatic int coin_value(input bit [1:0] c);
        case (c)
            2'd1:    return 5;
            2'd2:    return 10;
            2'd3:    return 25;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_db = 0; m_dbd = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_ready = 1; m_emit = -1000; m_edge = 0;
        m_in = 0; m_conf = 0; m_err = 0; m_total = 0;
    endtask

    task automatic model_edge();
        bit [3:0] p;
        int       np;
        p  = m_db & ~m_dbd;
        np = $countones(p);
        if (m_conf) begin
            m_total = m_total + coin_value(m_in);
            if (m_total > 4095) m_total = 4095;
        end
        m_conf = 0;
        m_err  = 0;
        if (m_ready) begin
            if (np == 1) begin
                for (int i = 0; i < 4; i++) if (p[i]) m_in = 2'(i);
                m_conf  = 1;
                m_ready = 0;
                m_emit  = m_edge;
            end else if (np > 1) begin
                m_err = 1;
            end
        end else begin
            if (np > 0) m_err = 1;
            if (m_edge >= m_emit + 1 + LCK && m_db == 0) begin
                m_in    = 0;
                m_ready = 1;
            end
        end
        m_dbd = m_db;
        for (int i = 0; i < 4; i++) begin
            if (m_h2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_db[i]  = ~m_db[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_h2 = m_h1;
        m_h1 = {sw_25, sw_10, sw_5, sw_cancel};
        m_edge++;
    endtask

    task automatic step();
        bit bad;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        nsteps++;
        if (confirm === 1'b1) begin
            n_conf++;
            last_code = in;
            if (first_conf < 0) first_conf = nsteps;
        end
        if (err === 1'b1) n_err++;
        checks++;
        bad = (in !== m_in) || (confirm !== m_conf) || (err !== m_err);
`ifdef COIN_TOTAL_EN
        bad = bad || (int'(total_cents) != m_total);
`endif
        if (bad) begin
            failures++;
            $display("FAIL model t=%0t in=%0d/%0d confirm=%0d/%0d err=%0d/%0d",
                     $time, in, m_in, confirm, m_conf, err, m_err);
        end
    endtask

    task automatic set_sw(input bit [3:0] s);
        {sw_25, sw_10, sw_5, sw_cancel} = s;
    endtask

    task automatic hold(input bit [3:0] s, input int n);
        set_sw(s);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic clear_counts();
        n_conf = 0; n_err = 0; nsteps = 0; first_conf = -1; last_code = 0;
    endtask

    // Called at a negedge: assert reset, check outputs immediately, hold two cycles.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset_in", int'(in), 0);
        chk("reset_confirm", int'(confirm), 0);
        chk("reset_err", int'(err), 0);
`ifdef COIN_TOTAL_EN
        chk("reset_total", int'(total_cents), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{4'b0001, 10, 1, 0, 2'd0};
        vecs[1] = '{4'b0010, 10, 1, 0, 2'd1};
        vecs[2] = '{4'b0100, 10, 1, 0, 2'd2};
        vecs[3] = '{4'b1000, 10, 1, 0, 2'd3};
        vecs[4] = '{4'b0110, 10, 0, 1, 2'd0};
        vecs[5] = '{4'b1001, 10, 0, 1, 2'd0};
        vecs[6] = '{4'b1111, 10, 0, 1, 2'd0};
        vecs[7] = '{4'b0010,  3, 0, 0, 2'd0};
        vecs[8] = '{4'b0010,  4, 1, 0, 2'd1};
        vecs[9] = '{4'b1000,  2, 0, 0, 2'd0};

        @(negedge clk);
        do_reset();

        // sw_10 held: one confirm, latency, code held until release
        clear_counts();
        hold(4'b0100, 20);
        chk("t1_confirms", n_conf, 1);
        chk("t1_latency", first_conf - 1, DEB + 2);
        chk("t1_code", int'(last_code), 2);
        chk("t1_err", n_err, 0);
        chk("t1_in_held", int'(in), 2);
        hold(4'b0000, 12);
        chk("t1_in_released", int'(in), 0);

        // Bouncy sw_25 then stable; then a short sw_5 glitch
        clear_counts();
        hold(4'b1000, 1);
        hold(4'b0000, 1);
        hold(4'b1000, 15);
        hold(4'b0000, 12);
        chk("t2_confirms", n_conf, 1);
        chk("t2_code", int'(last_code), 3);
        clear_counts();
        hold(4'b0010, 3);
        hold(4'b0000, 12);
        chk("t2_glitch_confirms", n_conf, 0);
        chk("t2_glitch_err", n_err, 0);

        // Simultaneous sw_5 and cancel
        clear_counts();
        hold(4'b0011, 15);
        hold(4'b0000, 12);
        chk("t3_confirms", n_conf, 0);
        chk("t3_err", n_err, 1);

        // Press during lockout is dropped
        clear_counts();
        set_sw(4'b0010);
        for (int k = 0; k < 20 && n_conf == 0; k++) step();
        chk("t4_first_confirm", n_conf, 1);
        hold(4'b0010, 2);
        hold(4'b0110, 15);
        chk("t4_confirms", n_conf, 1);
        chk("t4_err", n_err, 1);
        hold(4'b0000, 12);
        clear_counts();
        hold(4'b0100, 10);
        hold(4'b0000, 12);
        chk("t4_retry_confirms", n_conf, 1);
        chk("t4_retry_code", int'(last_code), 2);

        // 25c, 5c, cancel sequence
        do_reset();
        clear_counts();
        hold(4'b1000, 10); hold(4'b0000, 12);
        chk("t5_code_25", int'(last_code), 3);
        hold(4'b0010, 10); hold(4'b0000, 12);
        chk("t5_code_5", int'(last_code), 1);
        hold(4'b0001, 10); hold(4'b0000, 12);
        chk("t5_code_cancel", int'(last_code), 0);
        chk("t5_confirms", n_conf, 3);
`ifdef COIN_TOTAL_EN
        chk("t5_total", int'(total_cents), 30);
`endif

        // Reset mid-lock while sw_10 held
        clear_counts();
        set_sw(4'b0100);
        for (int k = 0; k < 20 && n_conf == 0; k++) step();
        chk("t6_pre_confirm", n_conf, 1);
        step();
        step();
        do_reset();
        clear_counts();
        hold(4'b0100, 20);
        chk("t6_confirms", n_conf, 1);
        chk("t6_latency", first_conf - 1, DEB + 2);
        chk("t6_code", int'(last_code), 2);
        hold(4'b0000, 12);

        // Table-driven vectors
        for (int v = 0; v < 10; v++) begin
            clear_counts();
            hold(vecs[v].sw, vecs[v].hold);
            hold(4'b0000, 15);
            chk($sformatf("vec%0d_confirms", v), n_conf, vecs[v].exp_conf);
            chk($sformatf("vec%0d_err", v), n_err, vecs[v].exp_err);
            if (vecs[v].exp_conf > 0)
                chk($sformatf("vec%0d_code", v), int'(last_code), int'(vecs[v].exp_code));
        end

        // Random switch activity against the model
        for (int c = 0; c < 150; c++) begin
            bit [3:0] s;
            if ($urandom_range(0, 2) == 0) s = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 1) == 0) s = 4'b0000;
            else s = 4'(1 << $urandom_range(0, 3));
            hold(s, $urandom_range(1, 10));
            if ($urandom_range(0, 29) == 0) do_reset();
        end
        hold(4'b0000, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
